// File: rtl/fir_waveform_reader.sv
// Streams a captured FIR waveform from the capture buffer to the UART TX byte port as one framed packet.
// state | meaning: IDLE wait | HDR0..2 sync, waveform number | RDREQ/RDCAP buffer read | SHI/SLO sample bytes | CSUM checksum
module fir_waveform_reader #(
    parameter int                NUM_SAMPLES = 500,
    parameter int                SAMPLE_W    = 14,
    parameter logic [7:0]        SYNC_BYTE   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          wave_number,
    output logic [10:0]          rd_addr,
    output logic                 rd_en,
    input  logic [SAMPLE_W-1:0]  rd_data,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [7:0]           dropped
);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] HDR0  = 4'd1;
    localparam logic [3:0] HDR1  = 4'd2;
    localparam logic [3:0] HDR2  = 4'd3;
    localparam logic [3:0] RDREQ = 4'd4;
    localparam logic [3:0] RDCAP = 4'd5;
    localparam logic [3:0] SHI   = 4'd6;
    localparam logic [3:0] SLO   = 4'd7;
    localparam logic [3:0] CSUM  = 4'd8;

    localparam logic [10:0] LAST_IDX = 11'(NUM_SAMPLES - 1);

    logic [3:0]          state;
    logic [15:0]         seen_wn;
    logic [15:0]         frame_wn;
    logic                pending;
    logic [10:0]         idx;
    logic [SAMPLE_W-1:0] sample;
    logic [7:0]          csum;
    logic [15:0]         sample_ext;
    logic                changed;
    logic                accept;

    assign sample_ext = 16'(sample);
    assign changed    = (wave_number != seen_wn);
    assign accept     = tx_valid && tx_ready;
    assign rd_en      = (state == RDREQ);
    assign busy       = (state != IDLE);

    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        case (state)
            HDR0: begin tx_data = SYNC_BYTE;        tx_valid = 1'b1; end
            HDR1: begin tx_data = frame_wn[15:8];   tx_valid = 1'b1; end
            HDR2: begin tx_data = frame_wn[7:0];    tx_valid = 1'b1; end
            SHI:  begin tx_data = sample_ext[15:8]; tx_valid = 1'b1; end
            SLO:  begin tx_data = sample_ext[7:0];  tx_valid = 1'b1; end
            CSUM: begin tx_data = csum;             tx_valid = 1'b1; end
            default: ;
        endcase
    end

    // A change seen while one frame is already queued is counted, not queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_wn <= 16'h0000;
            pending <= 1'b0;
            dropped <= 8'h00;
        end else begin
            if (changed) begin
                seen_wn <= wave_number;
                if (pending && dropped != 8'hFF) begin
                    dropped <= dropped + 8'd1;
                end
            end
            if (changed && !pending) begin
                pending <= 1'b1;
            end else if (state == IDLE && pending) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            frame_wn <= 16'h0000;
            idx      <= 11'd0;
            sample   <= '0;
            csum     <= 8'h00;
            rd_addr  <= 11'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        frame_wn <= seen_wn;
                        idx      <= 11'd0;
                        csum     <= 8'h00;
                        state    <= HDR0;
                    end
                end
                HDR0: begin
                    if (accept) state <= HDR1;
                end
                HDR1: begin
                    if (accept) begin
                        csum  <= csum + tx_data;
                        state <= HDR2;
                    end
                end
                HDR2: begin
                    if (accept) begin
                        csum    <= csum + tx_data;
                        rd_addr <= idx;
                        state   <= RDREQ;
                    end
                end
                RDREQ: state <= RDCAP;
                RDCAP: begin
                    sample <= rd_data;
                    state  <= SHI;
                end
                SHI: begin
                    if (accept) begin
                        csum  <= csum + tx_data;
                        state <= SLO;
                    end
                end
                SLO: begin
                    if (accept) begin
                        csum <= csum + tx_data;
                        if (idx == LAST_IDX) begin
                            state <= CSUM;
                        end else begin
                            idx     <= idx + 11'd1;
                            rd_addr <= idx + 11'd1;
                            state   <= RDREQ;
                        end
                    end
                end
                CSUM: begin
                    if (accept) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
